// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined RV32 core.
//
// Registers the execute outputs into EX/MEM, performs byte/half/word
// loads and stores against a local word-organised little-endian data
// memory, and registers the writeback value into MEM/WB.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               freeze both pipeline registers and block the store
//   flush               load a bubble into EX/MEM (MEM/WB still advances)
//   ex_valid .. rd      execute-stage outputs for the incoming instruction
//   alu_result_MEM,
//   rd_MEM, RegWrite_MEM   EX/MEM forwarding source
//   reg_write_data_WB,
//   rd_WB, RegWrite_WB     MEM/WB writeback / forwarding source
//   misaligned_WB       the WB instruction made a misaligned access
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ALU_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [4:0]  rd,
    output logic [31:0] alu_result_MEM,
    output logic [4:0]  rd_MEM,
    output logic        RegWrite_MEM,
    output logic [31:0] reg_write_data_WB,
    output logic [4:0]  rd_WB,
    output logic        RegWrite_WB,
    output logic        misaligned_WB
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ---------------- EX/MEM register ----------------
    logic        valid_q,     valid_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] sdata_q,     sdata_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic        memto_reg_q, memto_reg_d;
    logic [4:0]  rd_q,        rd_d;

    // ---------------- MEM/WB register ----------------
    logic [31:0] wb_data_q,   wb_data_d;
    logic [4:0]  wb_rd_q,     wb_rd_d;
    logic        wb_we_q,     wb_we_d;
    logic        wb_mis_q,    wb_mis_d;

    // ---------------- data memory ----------------
    // Zero at time 0 and deliberately outside the reset domain.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [AW-1:0] word_idx;
    logic [31:0]   rdata;
    logic          misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   wlanes;
    logic [31:0]   merged_d;
    logic          mem_we;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    // Addresses wrap modulo 4*DEPTH: only the word-index bits are used.
    assign word_idx = addr_q[AW+1:2];
    assign rdata    = mem_q[word_idx];

    // Byte accesses can never be misaligned; unlisted funct3 codes are
    // treated as aligned (they neither load nor store anything).
    always_comb begin
        misaligned = 1'b0;
        case (funct3_q)
            F3_H, F3_HU: misaligned = addr_q[0];
            F3_W:        misaligned = (addr_q[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    // Store: replicate the source across lanes so a byte enable alone
    // selects which lane lands; other lanes keep the old word.
    always_comb begin
        byte_en = 4'b0000;
        wlanes  = sdata_q;
        case (funct3_q)
            F3_B: begin
                byte_en = 4'b0001 << addr_q[1:0];
                wlanes  = {4{sdata_q[7:0]}};
            end
            F3_H: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{sdata_q[15:0]}};
            end
            F3_W: begin
                byte_en = 4'b1111;
                wlanes  = sdata_q;
            end
            default: byte_en = 4'b0000;
        endcase
        merged_d = rdata;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged_d[8*i +: 8] = wlanes[8*i +: 8];
        end
    end

    // valid_q is cleared asynchronously by reset, so a store pending when
    // reset arrives can never commit.
    assign mem_we = valid_q & mem_write_q & ~misaligned & ~stall;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[word_idx] <= merged_d;
    end

    // Load: lane select then extension; misaligned loads return zero.
    always_comb begin
        byte_sel = rdata[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? rdata[31:16] : rdata[15:0];
        load_data = 32'h0;
        case (funct3_q)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0;
        endcase
        if (misaligned) load_data = 32'h0;
    end

    // Next-state for both pipeline registers; stall is applied at the flop.
    always_comb begin
        valid_d     = ex_valid & ~flush;
        addr_d      = ALU_result;
        sdata_d     = store_data;
        funct3_d    = funct3;
        mem_read_d  = MemRead;
        mem_write_d = MemWrite;
        reg_write_d = RegWrite;
        memto_reg_d = MemtoReg;
        rd_d        = rd;

        wb_data_d = memto_reg_q ? load_data : addr_q;
        wb_rd_d   = rd_q;
        wb_we_d   = valid_q & reg_write_q
                    & ~(misaligned & (mem_read_q | mem_write_q));
        wb_mis_d  = valid_q & (mem_read_q | mem_write_q) & misaligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            addr_q      <= 32'h0;
            sdata_q     <= 32'h0;
            funct3_q    <= 3'b000;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            rd_q        <= 5'd0;
            wb_data_q   <= 32'h0;
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            wb_mis_q    <= 1'b0;
        end else if (!stall) begin
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            funct3_q    <= funct3_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            memto_reg_q <= memto_reg_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_mis_q    <= wb_mis_d;
        end
    end

    assign alu_result_MEM    = addr_q;
    assign rd_MEM            = rd_q;
    assign RegWrite_MEM      = valid_q & reg_write_q;
    assign reg_write_data_WB = wb_data_q;
    assign rd_WB             = wb_rd_q;
    assign RegWrite_WB       = wb_we_q;
    assign misaligned_WB     = wb_mis_q;

endmodule
